axi4s_mux_arb: RTL and testbench
================================

# axi4s_mux_arb

Packet-aware AXI4-S N:1 multiplexer, the parametrised successor to the single-mode round-robin mux. It arbitrates between `nr_of_streams_p` input streams in round-robin or fixed-priority mode and locks the grant from the first beat to `tlast`. Output is registered through a 2-entry skid buffer, so there is full AXI4-S backpressure and no combinational path from output to input. It sits in front of shared single-port consumers such as DMA writers and serialisers.

## Interface
- `nr_of_streams_p`, default 4: number of input streams, 2 to 16.
- `tdata_width_p`, default 32: data width in bits.
- `tid_bit_width_p`, default `$clog2(nr_of_streams_p)`: output tid width.
- `arb_mode_p`, default `ARB_RR_E`: arbitration mode, `ARB_RR_E` or `ARB_FIXED_E`; type `axi4s_mux_pkg::arb_mode_t`.
- `clk` in 1: clock; the only clock domain.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `axi4s_i_tvalid` in N: per-stream valid.
- `axi4s_i_tready` out N: per-stream ready; one-hot or zero.
- `axi4s_i_tlast` in N: per-stream last.
- `axi4s_i_tdata` in N x `tdata_width_p`: packed per-stream data.
- `axi4s_o_tvalid` out 1: output valid.
- `axi4s_o_tready` in 1: output ready.
- `axi4s_o_tlast` out 1: output last.
- `axi4s_o_tid` out `tid_bit_width_p`: index of the source stream.
- `axi4s_o_tdata` out `tdata_width_p`: output data.
- `grant_locked` out 1: high while the FSM is in LOCKED.
- `grant_idx` out `tid_bit_width_p`: current or last granted stream.

## Operation
**Reset.** While `rst` is high, on every clock edge:
- All outputs go to 0; this includes `axi4s_i_tready`, `axi4s_o_*`, `grant_*` and the skid-buffer contents.
- The RR pointer goes to 0 and the FSM to ARB.
- A reset mid-packet discards buffered beats. No partial-packet completion is attempted.

**FSM, ARB state.**
- All `axi4s_i_tready` are 0.
- If any `axi4s_i_tvalid` is high, select a winner, register it into `grant_idx`, and go to LOCKED.
- RR mode: the winner is the first valid index searching upward from the pointer, with wrap-around modulo N.
- Fixed mode: the winner is the lowest valid index.
- If no input is valid, the FSM stays in ARB and the pointer is unchanged.

**FSM, LOCKED state.**
- `axi4s_i_tready[grant_idx] = skid_in_ready`. All other ready bits are 0.
- A beat transfers when the granted valid and ready are both high.
- The beat pushed into the skid buffer carries {tdata, tlast, tid = `grant_idx`}.
- A transfer with tlast high returns the FSM to ARB. In RR mode the pointer then becomes `grant_idx`+1, wrapping from N-1 to 0.
- The granted input dropping tvalid mid-packet does NOT release the lock. The FSM waits for tlast.

**Skid buffer.**
- Entry 0 drives `axi4s_o_*`. Entry 1 holds the overflow beat.
- `skid_in_ready` is the registered value of !entry1_valid.
- A push goes to entry 0 if entry 0 is empty or is being popped in the same cycle; otherwise it goes to entry 1.
- A pop while entry 1 is valid moves entry 1 into entry 0.
- Simultaneous push and pop with the buffer full is impossible, because `skid_in_ready` is 0 in that case.
- Once `axi4s_o_tvalid` is asserted, `tvalid`, `tdata`, `tlast` and `tid` hold stable until the beat is accepted.

## Timing
- Arbitration: a valid input first seen in ARB at cycle N causes `grant_locked` to be 1 and the granted `axi4s_i_tready` to be high at cycle N+1.
- There is exactly one ARB bubble cycle between consecutive packets, even back-to-back from the same stream.
- Data latency: a beat accepted at cycle N is on `axi4s_o_*` at cycle N+1 when the buffer was empty.
- Throughput: 1 beat per cycle within a packet while `axi4s_o_tready` is high.
- Backpressure: after `axi4s_o_tready` falls, at most one further beat is accepted into entry 1. Input ready drops the following cycle.
- `axi4s_i_tready` is a function of registered state only. It never depends combinationally on `axi4s_o_tready` or `axi4s_i_tvalid`.

## Structure
- Package `axi4s_mux_pkg` holds the `arb_mode_t` enum (`ARB_RR_E`, `ARB_FIXED_E`) and the `mux_state_t` enum (`ARB_E`, `LOCKED_E`).
- Sub-module `axi4s_skid_buffer`, parametrised on payload width (`tdata_width_p`+1+`tid_bit_width_p`). It is reusable across the axi4s library.
- The arbiter search is a combinational function in the top module. The FSM and pointer are in a single `always_ff`.

## Test plan
- **RR fairness.** N=4, all streams continuously valid, each sending 2-beat packets, `axi4s_o_tready`=1. Required: the output tid sequence is 0,1,2,3,0,… and every packet's beats are contiguous, with one bubble cycle between packets.
- **Fixed priority.** Streams 1 and 3 are valid continuously. Required: only tid=1 appears. After stream 1 deasserts, tid=3 is granted in the next ARB cycle.
- **Lock hold.** The granted stream 2 drops tvalid for 5 cycles mid-packet while stream 0 is valid. Required: stream 0 is never readied, and the packet from stream 2 completes after it resumes.
- **Backpressure.** Drive `axi4s_o_tready`=0 for 10 cycles during a 16-beat packet. Required: at most 2 beats are buffered, no beat is lost or duplicated, output data is stable while stalled, and the data sequence matches the input exactly.
- **Pointer wrap.** The last grant is stream N-1 and only stream 0 is valid. Required: the next grant is 0. Then, with streams 0 and 1 both valid, the grant is 1.
- **Mid-packet reset.** Assert `rst` for 1 cycle at beat 3 of 8. Required: the next cycle shows all outputs 0 and the FSM in ARB, and a subsequent grant goes to the lowest valid index from pointer 0.

Source files
------------

// File: rtl/axi4s_mux_pkg.sv
// Shared types for the packet-aware AXI4-S N:1 multiplexer.
package axi4s_mux_pkg;

  typedef enum logic {
    ARB_RR_E    = 1'b0,
    ARB_FIXED_E = 1'b1
  } arb_mode_t;

  typedef enum logic {
    ARB_E    = 1'b0,
    LOCKED_E = 1'b1
  } mux_state_t;

endpackage

// File: rtl/axi4s_skid_buffer.sv
// Two-entry AXI4-S skid buffer: entry 0 drives the output, entry 1 absorbs one overflow beat.
module axi4s_skid_buffer #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width_p-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width_p-1:0] out_data
);

  logic               e0_valid_q, e0_valid_d, e1_valid_q, e1_valid_d, ready_q;
  logic [width_p-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic               push, pop;

  assign push = in_valid & ready_q;
  assign pop  = e0_valid_q & out_ready;

  always_comb begin
    e0_valid_d = e0_valid_q;
    e0_data_d  = e0_data_q;
    e1_valid_d = e1_valid_q;
    e1_data_d  = e1_data_q;
    if (pop) begin
      // Push cannot coincide with a full-buffer pop: ready_q is low whenever entry 1 is valid.
      if (e1_valid_q) begin
        e0_data_d  = e1_data_q;
        e1_valid_d = 1'b0;
      end else if (push) begin
        e0_data_d = in_data;
      end else begin
        e0_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!e0_valid_q) begin
        e0_valid_d = 1'b1;
        e0_data_d  = in_data;
      end else begin
        e1_valid_d = 1'b1;
        e1_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
      e0_data_q  <= '0;
      e1_data_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      e0_valid_q <= e0_valid_d;
      e1_valid_q <= e1_valid_d;
      e0_data_q  <= e0_data_d;
      e1_data_q  <= e1_data_d;
      ready_q    <= !e1_valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = e0_valid_q;
  assign out_data  = e0_data_q;

endmodule

// File: rtl/axi4s_mux_arb.sv
// Packet-locked N:1 AXI4-S mux with round-robin or fixed-priority arbitration and a
// registered skid-buffer output stage.
module axi4s_mux_arb
  import axi4s_mux_pkg::*;
#(
  parameter int unsigned nr_of_streams_p = 4,
  parameter int unsigned tdata_width_p   = 32,
  parameter int unsigned tid_bit_width_p = $clog2(nr_of_streams_p),
  parameter arb_mode_t   arb_mode_p      = ARB_RR_E
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [nr_of_streams_p-1:0]               axi4s_i_tvalid,
  output logic [nr_of_streams_p-1:0]               axi4s_i_tready,
  input  logic [nr_of_streams_p-1:0]               axi4s_i_tlast,
  input  logic [nr_of_streams_p*tdata_width_p-1:0] axi4s_i_tdata,
  output logic                                     axi4s_o_tvalid,
  input  logic                                     axi4s_o_tready,
  output logic                                     axi4s_o_tlast,
  output logic [tid_bit_width_p-1:0]               axi4s_o_tid,
  output logic [tdata_width_p-1:0]                 axi4s_o_tdata,
  output logic                                     grant_locked,
  output logic [tid_bit_width_p-1:0]               grant_idx
);

  localparam int unsigned payload_width_lp = tdata_width_p + 1 + tid_bit_width_p;

  // RR searches upward from ptr with wrap; fixed mode always searches from index 0.
  function automatic logic [tid_bit_width_p-1:0] arb_pick(
    input logic [nr_of_streams_p-1:0] valid,
    input logic [tid_bit_width_p-1:0] ptr
  );
    logic        found;
    int unsigned idx;
    arb_pick = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < nr_of_streams_p; i++) begin
      idx = (arb_mode_p == ARB_RR_E) ? i + 32'(ptr) : i;
      if (idx >= nr_of_streams_p) idx = idx - nr_of_streams_p;
      if (!found && valid[idx]) begin
        found    = 1'b1;
        arb_pick = tid_bit_width_p'(idx);
      end
    end
  endfunction

  mux_state_t                   state_q;
  logic [tid_bit_width_p-1:0]   ptr_q, grant_idx_q;
  logic                         skid_in_valid, skid_in_ready, beat_fire;
  logic [tdata_width_p-1:0]     sel_tdata;
  logic [payload_width_lp-1:0]  skid_in_data, skid_out_data;

  assign sel_tdata     = axi4s_i_tdata[32'(grant_idx_q)*tdata_width_p +: tdata_width_p];
  assign skid_in_valid = (state_q == LOCKED_E) & axi4s_i_tvalid[grant_idx_q];
  assign skid_in_data  = {sel_tdata, axi4s_i_tlast[grant_idx_q], grant_idx_q};
  assign beat_fire     = skid_in_valid & skid_in_ready;

  // Ready depends only on registered state, never on tvalid or the output ready.
  always_comb begin
    axi4s_i_tready = '0;
    if (state_q == LOCKED_E) axi4s_i_tready[grant_idx_q] = skid_in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_E;
      ptr_q       <= '0;
      grant_idx_q <= '0;
    end else begin
      unique case (state_q)
        ARB_E: begin
          if (|axi4s_i_tvalid) begin
            grant_idx_q <= arb_pick(axi4s_i_tvalid, ptr_q);
            state_q     <= LOCKED_E;
          end
        end
        LOCKED_E: begin
          if (beat_fire && axi4s_i_tlast[grant_idx_q]) begin
            state_q <= ARB_E;
            if (arb_mode_p == ARB_RR_E) begin
              ptr_q <= (grant_idx_q == tid_bit_width_p'(nr_of_streams_p - 1)) ?
                       '0 : grant_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ARB_E;
      endcase
    end
  end

  axi4s_skid_buffer #(
    .width_p(payload_width_lp)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .in_data  (skid_in_data),
    .out_valid(axi4s_o_tvalid),
    .out_ready(axi4s_o_tready),
    .out_data (skid_out_data)
  );

  assign {axi4s_o_tdata, axi4s_o_tlast, axi4s_o_tid} = skid_out_data;
  assign grant_locked = (state_q == LOCKED_E);
  assign grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_axi4s_mux_arb.sv
// Directed bench for axi4s_mux_arb: one RR instance and one fixed-priority instance share inputs.
module tb_axi4s_mux_arb;
  import axi4s_mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   i_tvalid, i_tlast;
  logic [N*W-1:0] i_tdata;
  logic           o_tready;

  logic [N-1:0]  rr_tready, fx_tready;
  logic          rr_tvalid, fx_tvalid, rr_tlast, fx_tlast, rr_locked, fx_locked;
  logic [TW-1:0] rr_tid, fx_tid, rr_gidx, fx_gidx;
  logic [W-1:0]  rr_tdata, fx_tdata;

  axi4s_mux_arb #(
    .nr_of_streams_p(N), .tdata_width_p(W), .tid_bit_width_p(TW), .arb_mode_p(ARB_RR_E)
  ) dut_rr (
    .clk(clk), .rst(rst),
    .axi4s_i_tvalid(i_tvalid), .axi4s_i_tready(rr_tready), .axi4s_i_tlast(i_tlast),
    .axi4s_i_tdata(i_tdata), .axi4s_o_tvalid(rr_tvalid), .axi4s_o_tready(o_tready),
    .axi4s_o_tlast(rr_tlast), .axi4s_o_tid(rr_tid), .axi4s_o_tdata(rr_tdata),
    .grant_locked(rr_locked), .grant_idx(rr_gidx)
  );

  axi4s_mux_arb #(
    .nr_of_streams_p(N), .tdata_width_p(W), .tid_bit_width_p(TW), .arb_mode_p(ARB_FIXED_E)
  ) dut_fx (
    .clk(clk), .rst(rst),
    .axi4s_i_tvalid(i_tvalid), .axi4s_i_tready(fx_tready), .axi4s_i_tlast(i_tlast),
    .axi4s_i_tdata(i_tdata), .axi4s_o_tvalid(fx_tvalid), .axi4s_o_tready(o_tready),
    .axi4s_o_tlast(fx_tlast), .axi4s_o_tid(fx_tid), .axi4s_o_tdata(fx_tdata),
    .grant_locked(fx_locked), .grant_idx(fx_gidx)
  );

  logic          use_fx = 1'b0;
  logic [N-1:0]  act_tready;
  logic          act_tvalid, act_tlast;
  logic [TW-1:0] act_tid;
  logic [W-1:0]  act_tdata;
  assign act_tready = use_fx ? fx_tready : rr_tready;
  assign act_tvalid = use_fx ? fx_tvalid : rr_tvalid;
  assign act_tlast  = use_fx ? fx_tlast  : rr_tlast;
  assign act_tid    = use_fx ? fx_tid    : rr_tid;
  assign act_tdata  = use_fx ? fx_tdata  : rr_tdata;

  // Source model: stream s sends packets of len[s] beats, data = {s, packet, beat}.
  int           beat[N], pkt[N], len[N];
  logic [N-1:0] en;
  logic [TW-1:0] q_tid[$];
  logic [W-1:0]  q_data[$];
  logic          q_last[$];
  int            q_cyc[$];
  int            cyc = 0;
  int            in_cnt, out_cnt;
  int            passed = 0, total = 0;

  function automatic logic [W-1:0] exp_data(input int s, input int p, input int b);
    return {s[7:0], p[7:0], b[15:0]};
  endfunction

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      i_tvalid[s]         = en[s];
      i_tlast[s]          = (beat[s] == len[s] - 1);
      i_tdata[s*W +: W]   = exp_data(s, pkt[s], beat[s]);
    end
  endtask

  // Called at a negedge: drive, record handshakes due at the coming posedge, advance one cycle.
  task automatic tick();
    logic [N-1:0] fire;
    drive();
    #1;
    fire = i_tvalid & act_tready;
    if (act_tvalid && o_tready) begin
      q_tid.push_back(act_tid);
      q_data.push_back(act_tdata);
      q_last.push_back(act_tlast);
      q_cyc.push_back(cyc);
      out_cnt++;
    end
    in_cnt += $countones(fire);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int s = 0; s < N; s++) begin
      if (fire[s]) begin
        if (beat[s] == len[s] - 1) begin
          beat[s] = 0;
          pkt[s]++;
        end else begin
          beat[s]++;
        end
      end
    end
  endtask

  task automatic clear_sources();
    for (int s = 0; s < N; s++) begin
      beat[s] = 0;
      pkt[s]  = 0;
      len[s]  = 2;
    end
  endtask

  task automatic reset_all();
    rst      = 1'b1;
    en       = '0;
    o_tready = 1'b1;
    clear_sources();
    tick();
    tick();
    rst = 1'b0;
    q_tid.delete();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    in_cnt  = 0;
    out_cnt = 0;
  endtask

  task automatic test_reset();
    use_fx = 1'b0;
    reset_all();
    total++; if (rr_tvalid !== 1'b0) $display("FAIL reset_o_tvalid: got %b want 0", rr_tvalid);
    else passed++;
    total++; if (rr_tlast !== 1'b0) $display("FAIL reset_o_tlast: got %b want 0", rr_tlast);
    else passed++;
    total++; if (rr_tid !== 2'd0) $display("FAIL reset_o_tid: got %0d want 0", rr_tid);
    else passed++;
    total++; if (rr_tdata !== 32'h0) $display("FAIL reset_o_tdata: got %h want 0", rr_tdata);
    else passed++;
    total++; if (rr_tready !== 4'b0000) $display("FAIL reset_i_tready: got %b want 0000", rr_tready);
    else passed++;
    total++;
    if (rr_locked !== 1'b0 || rr_gidx !== 2'd0)
      $display("FAIL reset_grant: locked %b idx %0d want 0 0", rr_locked, rr_gidx);
    else passed++;
    total++;
    if (fx_tvalid !== 1'b0 || fx_tready !== 4'b0000 || fx_locked !== 1'b0)
      $display("FAIL reset_fixed: tvalid %b tready %b locked %b want 0", fx_tvalid, fx_tready,
               fx_locked);
    else passed++;
  endtask

  task automatic test_rr_fairness();
    logic err_tid = 1'b0, err_data = 1'b0, err_gap = 1'b0;
    int   npk;
    use_fx = 1'b0;
    reset_all();
    en = 4'b1111;
    tick();
    total++;
    if (rr_locked !== 1'b1 || rr_tready !== 4'b0001)
      $display("FAIL rr_first_grant: locked %b tready %b want 1 0001", rr_locked, rr_tready);
    else passed++;
    for (int i = 0; i < 30; i++) tick();
    total++;
    if (q_tid.size() < 16) $display("FAIL rr_beat_count: got %0d want >=16", q_tid.size());
    else passed++;
    npk = (q_tid.size() / 2 < 8) ? q_tid.size() / 2 : 8;
    for (int k = 0; k < npk; k++) begin
      logic [TW-1:0] wt;
      wt = 2'(k % 4);
      for (int b = 0; b < 2; b++) begin
        int j;
        j = 2 * k + b;
        if (q_tid[j] !== wt) begin
          if (!err_tid) $display("FAIL rr_tid_seq: beat %0d tid %0d want %0d", j, q_tid[j], wt);
          err_tid = 1'b1;
        end
        if (q_data[j] !== exp_data(k % 4, k / 4, b) || q_last[j] !== (b == 1)) begin
          if (!err_data)
            $display("FAIL rr_data: beat %0d got %h/%b want %h/%b", j, q_data[j], q_last[j],
                     exp_data(k % 4, k / 4, b), b == 1);
          err_data = 1'b1;
        end
      end
      if (q_cyc[2*k+1] != q_cyc[2*k] + 1 || (k > 0 && q_cyc[2*k] != q_cyc[2*k-1] + 2)) begin
        if (!err_gap) $display("FAIL rr_spacing: packet %0d at cycle %0d", k, q_cyc[2*k]);
        err_gap = 1'b1;
      end
    end
    total++; if (!err_tid) passed++;
    total++; if (!err_data) passed++;
    total++; if (!err_gap) passed++;
  endtask

  task automatic test_fixed_priority();
    logic err = 1'b0;
    use_fx = 1'b1;
    reset_all();
    en = 4'b1010;
    for (int i = 0; i < 40 && pkt[1] < 3; i++) begin
      tick();
      if (fx_tready[3]) err = 1'b1;
    end
    foreach (q_tid[j]) if (q_tid[j] !== 2'd1) err = 1'b1;
    total++;
    if (err || q_tid.size() < 4)
      $display("FAIL fixed_only_tid1: beats %0d stray %b want only tid 1", q_tid.size(), err);
    else passed++;
    en[1] = 1'b0;
    tick();
    total++;
    if (fx_locked !== 1'b1 || fx_gidx !== 2'd3)
      $display("FAIL fixed_fallback: locked %b idx %0d want 1 3", fx_locked, fx_gidx);
    else passed++;
    use_fx = 1'b0;
  endtask

  task automatic test_lock_hold();
    logic err_rdy = 1'b0, err_lock = 1'b0, err_pkt = 1'b0;
    use_fx = 1'b0;
    reset_all();
    en     = 4'b0100;
    len[2] = 6;
    for (int i = 0; i < 20 && beat[2] < 2; i++) tick();
    en = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rr_tready[0]) err_rdy = 1'b1;
      if (rr_locked !== 1'b1 || rr_gidx !== 2'd2) err_lock = 1'b1;
    end
    en = 4'b0101;
    for (int i = 0; i < 20 && pkt[2] < 1; i++) begin
      tick();
      if (rr_tready[0]) err_rdy = 1'b1;
    end
    en = 4'b0000;
    tick();
    tick();
    total++; if (err_rdy) $display("FAIL lock_stream0_ready: got 1 want 0"); else passed++;
    total++;
    if (err_lock) $display("FAIL lock_hold_grant: lost lock on stream 2 while it idled");
    else passed++;
    if (q_tid.size() < 6) err_pkt = 1'b1;
    else
      for (int b = 0; b < 6; b++)
        if (q_tid[b] !== 2'd2 || q_data[b] !== exp_data(2, 0, b) || q_last[b] !== (b == 5))
          err_pkt = 1'b1;
    total++;
    if (err_pkt) $display("FAIL lock_packet: got %0d beats want 6 in order from tid 2",
                          q_tid.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    logic err_stable = 1'b0, err_occ = 1'b0, err_seq = 1'b0;
    use_fx = 1'b0;
    reset_all();
    en     = 4'b0001;
    len[0] = 16;
    for (int i = 0; i < 20 && beat[0] < 4; i++) tick();
    o_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rr_tvalid !== 1'b1 || rr_tdata !== exp_data(0, 0, 3) || rr_tlast !== 1'b0)
        err_stable = 1'b1;
      if (in_cnt - out_cnt > 2) err_occ = 1'b1;
    end
    total++;
    if (beat[0] != 5) $display("FAIL bp_accepted_in_stall: got %0d beats want 5", beat[0]);
    else passed++;
    o_tready = 1'b1;
    for (int i = 0; i < 40 && pkt[0] < 1; i++) begin
      tick();
      if (in_cnt - out_cnt > 2) err_occ = 1'b1;
    end
    en = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (err_stable) $display("FAIL bp_stable: output moved while stalled, want beat 3 held");
    else passed++;
    total++; if (err_occ) $display("FAIL bp_occupancy: more than 2 beats buffered"); else passed++;
    if (q_tid.size() != 16) err_seq = 1'b1;
    else
      for (int b = 0; b < 16; b++)
        if (q_data[b] !== exp_data(0, 0, b) || q_last[b] !== (b == 15) || q_tid[b] !== 2'd0)
          err_seq = 1'b1;
    total++;
    if (err_seq) $display("FAIL bp_sequence: got %0d beats want 16 in order", q_tid.size());
    else passed++;
  endtask

  task automatic test_pointer_wrap();
    use_fx = 1'b0;
    reset_all();
    en = 4'b1000;
    for (int i = 0; i < 20 && pkt[3] < 1; i++) tick();
    en = 4'b0001;
    tick();
    total++;
    if (rr_locked !== 1'b1 || rr_gidx !== 2'd0)
      $display("FAIL wrap_grant0: locked %b idx %0d want 1 0", rr_locked, rr_gidx);
    else passed++;
    for (int i = 0; i < 20 && pkt[0] < 1; i++) tick();
    en = 4'b0011;
    tick();
    total++;
    if (rr_locked !== 1'b1 || rr_gidx !== 2'd1)
      $display("FAIL wrap_grant1: locked %b idx %0d want 1 1", rr_locked, rr_gidx);
    else passed++;
  endtask

  task automatic test_mid_reset();
    use_fx = 1'b0;
    reset_all();
    en     = 4'b0100;
    len[2] = 8;
    for (int i = 0; i < 20 && beat[2] < 3; i++) tick();
    rst = 1'b1;
    tick();
    total++;
    if (rr_tvalid !== 1'b0 || rr_tdata !== 32'h0 || rr_tlast !== 1'b0 || rr_tid !== 2'd0)
      $display("FAIL midrst_output: tvalid %b tdata %h tlast %b tid %0d want all 0",
               rr_tvalid, rr_tdata, rr_tlast, rr_tid);
    else passed++;
    total++;
    if (rr_tready !== 4'b0000 || rr_locked !== 1'b0 || rr_gidx !== 2'd0)
      $display("FAIL midrst_fsm: tready %b locked %b idx %0d want 0000 0 0", rr_tready,
               rr_locked, rr_gidx);
    else passed++;
    rst = 1'b0;
    clear_sources();
    en = 4'b0110;
    tick();
    total++;
    if (rr_locked !== 1'b1 || rr_gidx !== 2'd1 || rr_tready !== 4'b0010)
      $display("FAIL midrst_regrant: locked %b idx %0d tready %b want 1 1 0010", rr_locked,
               rr_gidx, rr_tready);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_lock_hold();
    test_backpressure();
    test_pointer_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
